// File: rtl/zx48_timing_pkg.sv
// ZX Spectrum 48K frame geometry shared by the CPU timing, video and memory blocks.
// Also holds the contended-access decode used when stalling the CPU.
package zx48_timing_pkg;

    localparam int unsigned CNT_W      = 9;
    localparam int unsigned HTOTAL     = 224;
    localparam int unsigned VTOTAL     = 312;
    localparam int unsigned INT_LINE   = 248;
    localparam int unsigned INT_LEN    = 32;
    localparam int unsigned CONT_FIRST = 64;
    localparam int unsigned CONT_LAST  = 255;
    localparam int unsigned CONT_HEND  = 128;

    typedef logic [CNT_W-1:0] count_t;

    // Bus strobes are active low: a high strobe means the cycle is set up but not yet issued.
    function automatic logic is_contended(input logic [15:0] a, input logic mreq,
                                          input logic iorq, input logic rfsh);
        return ((a[15:14] == 2'b01) & mreq & rfsh) | (~a[0] & iorq);
    endfunction

endpackage

// File: rtl/ce_div.sv
// Phase counter dividing the system clock into T-states; flags the last phase and
// the phase just before mid T-state so the parent can register its enables.
module ce_div #(
    parameter  int unsigned CLKDIV = 16,
    localparam int unsigned PW     = $clog2(CLKDIV)
) (
    input  logic clock,
    input  logic reset,
    output logic tick,
    output logic mid
);

    logic [PW-1:0] phase;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase <= '0;
        end else if (tick) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

    assign tick = (phase == PW'(CLKDIV - 1));
    assign mid  = (phase == PW'(CLKDIV / 2 - 1));

endmodule

// File: rtl/cpu_timing.sv
// Z80 clock-enable generator: 48K frame counters, contention stalls and frame interrupt.
// Counters free-run; contention only suppresses cep/cen for the stalled T-state.
module cpu_timing
    import zx48_timing_pkg::*;
#(
    parameter int unsigned CLKDIV     = 16,
    parameter int unsigned H_TOTAL    = HTOTAL,
    parameter int unsigned V_TOTAL    = VTOTAL,
    parameter int unsigned I_LINE     = INT_LINE,
    parameter int unsigned I_LEN      = INT_LEN,
    parameter int unsigned C_FIRST    = CONT_FIRST,
    parameter int unsigned C_LAST     = CONT_LAST,
    parameter int unsigned C_HEND     = CONT_HEND
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cont_en,
    input  logic [15:0] a,
    input  logic        mreq,
    input  logic        iorq,
    input  logic        rfsh,
    output logic        cep,
    output logic        cen,
    output logic        mi,
    output count_t      hcount,
    output count_t      vcount
);

    logic   tick, mid;
    logic   stall, stall_next, in_window, in_int;
    count_t h_next, v_next;

    ce_div #(.CLKDIV(CLKDIV)) u_ce_div (
        .clock (clock),
        .reset (reset),
        .tick  (tick),
        .mid   (mid)
    );

    // Decisions look at the T-state about to start, so cep/cen/mi line up with the new counts.
    // NOTE: every variable driven here gets a default first so no path can infer a latch.
    always_comb begin
        h_next = hcount + 1'b1;
        v_next = vcount;
        if (hcount == count_t'(H_TOTAL - 1)) begin
            h_next = '0;
            v_next = (vcount == count_t'(V_TOTAL - 1)) ? '0 : vcount + 1'b1;
        end
        in_window  = (v_next >= count_t'(C_FIRST)) && (v_next <= count_t'(C_LAST))
                   && (h_next < count_t'(C_HEND)) && (h_next[2:0] < 3'd6);
        stall_next = cont_en & is_contended(a, mreq, iorq, rfsh) & in_window;
        in_int     = (v_next == count_t'(I_LINE)) && (h_next < count_t'(I_LEN));
    end

    // NOTE: state and registered outputs use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hcount <= '0;
            vcount <= '0;
            stall  <= 1'b0;
            cep    <= 1'b0;
            cen    <= 1'b0;
            mi     <= 1'b1;
        end else begin
            cep <= tick & ~stall_next;
            cen <= mid & ~stall;
            if (tick) begin
                hcount <= h_next;
                vcount <= v_next;
                stall  <= stall_next;
                mi     <= ~in_int;
            end
        end
    end

endmodule

// File: tb/tb_cpu_timing.sv
// Directed bench for cpu_timing on a shrunken frame (32 T-states x 10 lines) so a whole
// frame fits in a short run; clock enables keep the production 16-clock T-state.
module tb_cpu_timing;

    localparam int unsigned HT = 32, VT = 10, ILINE = 8, ILEN = 4;
    localparam int unsigned CF = 3, CL = 5, CH = 16, DIV = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cont_en = 1'b0;
    logic [15:0] a = 16'h0000;
    logic        mreq = 1'b0;
    logic        iorq = 1'b0;
    logic        rfsh = 1'b1;
    logic        cep, cen, mi;
    logic [8:0]  hcount, vcount;

    int vectors = 0;
    int miscompares = 0;

    cpu_timing #(
        .CLKDIV(DIV), .H_TOTAL(HT), .V_TOTAL(VT), .I_LINE(ILINE), .I_LEN(ILEN),
        .C_FIRST(CF), .C_LAST(CL), .C_HEND(CH)
    ) dut (
        .clock(clock), .reset(reset), .cont_en(cont_en), .a(a), .mreq(mreq),
        .iorq(iorq), .rfsh(rfsh), .cep(cep), .cen(cen), .mi(mi),
        .hcount(hcount), .vcount(vcount)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Advance to the first sample (phase 0) of T-state (v,h); bounded by ~1.5 frames.
    task automatic goto(input int v, input int h);
        bit         found = 1'b0;
        logic [8:0] ph = hcount, pv = vcount;
        for (int i = 0; i < 8000 && !found; i++) begin
            @(negedge clock);
            if (hcount == 9'(h) && vcount == 9'(v) && (ph != 9'(h) || pv != 9'(v))) found = 1'b1;
            ph = hcount;
            pv = vcount;
        end
        check($sformatf("reach_v%0d_h%0d", v, h), 32'(found), 32'd1);
    endtask

    // Number of samples after reset release until the first cep (0 if none within 40).
    task automatic first_cep(output int pos);
        pos = 0;
        for (int i = 1; i <= 40 && pos == 0; i++) begin
            @(negedge clock);
            if (cep) pos = i;
        end
    endtask

    int pos, n_cep, n_cen, n_both, n_mi;

    initial begin
        // Reset state
        tick(2);
        check("rst_cep", 32'(cep), 32'd0);
        check("rst_cen", 32'(cen), 32'd0);
        check("rst_mi", 32'(mi), 32'd1);
        check("rst_hcount", 32'(hcount), 32'd0);
        check("rst_vcount", 32'(vcount), 32'd0);
        reset = 1'b1;
        first_cep(pos);
        check("first_cep_pos", 32'(pos), 32'd16);
        check("first_cep_h", 32'(hcount), 32'd1);

        // Free-run spacing: cen 8 clocks after cep, next cep 16 after
        tick(8);
        check("cen_at_8", 32'(cen), 32'd1);
        check("cep_at_8", 32'(cep), 32'd0);
        tick(8);
        check("cep_at_16", 32'(cep), 32'd1);
        check("h_at_16", 32'(hcount), 32'd2);

        // Line wrap
        goto(0, HT - 1);
        tick(16);
        check("hwrap_h", 32'(hcount), 32'd0);
        check("hwrap_v", 32'(vcount), 32'd1);

        // Memory contention; line 1 is above the window
        cont_en = 1'b1; a = 16'h4000; mreq = 1'b1; rfsh = 1'b1; iorq = 1'b0;
        goto(1, 2);
        check("above_window_cep", 32'(cep), 32'd1);

        goto(CF, 0);
        n_cep = 0; n_cen = 0;
        for (int i = 0; i < 96; i++) begin
            if (i > 0) @(negedge clock);
            n_cep += int'(cep);
            n_cen += int'(cen);
        end
        check("stall_ceps_h0_5", 32'(n_cep), 32'd0);
        check("stall_cens_h0_5", 32'(n_cen), 32'd0);
        tick(1);
        check("resume_cep", 32'(cep), 32'd1);
        check("resume_h", 32'(hcount), 32'd6);
        goto(CF, 8);
        check("held_stall_h8", 32'(cep), 32'd0);
        goto(CF, CH);
        check("past_hend_cep", 32'(cep), 32'd1);

        // RFSH_n low and cont_en low never stall
        rfsh = 1'b0;
        goto(4, 1);
        check("rfsh_low_cep", 32'(cep), 32'd1);
        rfsh = 1'b1; cont_en = 1'b0;
        goto(4, 3);
        check("cont_off_cep", 32'(cep), 32'd1);
        cont_en = 1'b1;

        // I/O contention: even port stalls, odd port does not
        mreq = 1'b0; a = 16'h00FE; iorq = 1'b1;
        goto(5, 1);
        check("io_fe_cep", 32'(cep), 32'd0);
        tick(8);
        check("io_fe_cen", 32'(cen), 32'd0);
        a = 16'h00FF;
        goto(5, 9);
        check("io_ff_cep", 32'(cep), 32'd1);

        // Line below the window
        a = 16'h4000; mreq = 1'b1; iorq = 1'b0;
        goto(CL + 1, 0);
        check("below_window_cep", 32'(cep), 32'd1);

        // Interrupt edges
        cont_en = 1'b0; mreq = 1'b0;
        goto(ILINE, 0);
        check("mi_start", 32'(mi), 32'd0);
        goto(ILINE, ILEN - 1);
        tick(15);
        check("mi_last_clock", 32'(mi), 32'd0);
        tick(1);
        check("mi_end", 32'(mi), 32'd1);
        check("mi_end_h", 32'(hcount), 32'(ILEN));

        // Frame wrap
        goto(VT - 1, HT - 1);
        tick(16);
        check("vwrap_v", 32'(vcount), 32'd0);
        check("vwrap_h", 32'(hcount), 32'd0);

        // One whole frame with contention off
        n_cep = 0; n_cen = 0; n_both = 0; n_mi = 0;
        for (int i = 0; i < HT * VT * DIV; i++) begin
            if (i > 0) @(negedge clock);
            n_cep  += int'(cep);
            n_cen  += int'(cen);
            n_both += int'(cep & cen);
            n_mi   += int'(!mi);
        end
        check("frame_ceps", 32'(n_cep), 32'(HT * VT));
        check("frame_cens", 32'(n_cen), 32'(HT * VT));
        check("frame_both", 32'(n_both), 32'd0);
        check("frame_mi_clocks", 32'(n_mi), 32'(ILEN * DIV));
        check("frame_end_v", 32'(vcount), 32'(VT - 1));

        // Reset in the middle of a stalled T-state
        cont_en = 1'b1; a = 16'h4000; mreq = 1'b1; rfsh = 1'b1; iorq = 1'b0;
        goto(CF, 0);
        check("pre_reset_stalled", 32'(cep), 32'd0);
        tick(5);
        reset = 1'b0;
        #1;
        check("midrst_cep", 32'(cep), 32'd0);
        check("midrst_cen", 32'(cen), 32'd0);
        check("midrst_mi", 32'(mi), 32'd1);
        check("midrst_h", 32'(hcount), 32'd0);
        check("midrst_v", 32'(vcount), 32'd0);
        tick(2);
        reset = 1'b1;
        first_cep(pos);
        check("post_rst_first_cep", 32'(pos), 32'd16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
